// File: rtl/ysyx_22050612_pkg.sv
// Shared definitions for the ysyx_22050612 core: default register-file
// geometry, the register index type and the hardwired-zero register index.
package ysyx_22050612_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 5;
  localparam int DEFAULT_DATA_WIDTH = 64;

  // Index of the architectural zero register.
  localparam int ZERO_REG = 0;

  typedef logic [DEFAULT_ADDR_WIDTH-1:0] reg_idx_t;

endpackage

// File: rtl/ysyx_22050612_regfile_sb_if.sv
// Bus between the pipeline (master: decode/issue/writeback) and the
// register file with scoreboard (slave).
interface ysyx_22050612_regfile_sb_if
  import ysyx_22050612_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);

  // Writeback
  logic                  wen;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;
  // Issue allocation handshake
  logic                  alloc_valid;
  logic [ADDR_WIDTH-1:0] alloc_rd;
  logic                  alloc_ready;
  // Decode read ports
  logic [ADDR_WIDTH-1:0] rs1;
  logic [ADDR_WIDTH-1:0] rs2;
  logic [DATA_WIDTH-1:0] src1;
  logic [DATA_WIDTH-1:0] src2;
  logic                  rs1_busy;
  logic                  rs2_busy;
  // Sticky spurious-retire flag
  logic                  err;

  modport master (
    output wen, waddr, wdata, alloc_valid, alloc_rd, rs1, rs2,
    input  alloc_ready, src1, src2, rs1_busy, rs2_busy, err
  );

  modport slave (
    input  wen, waddr, wdata, alloc_valid, alloc_rd, rs1, rs2,
    output alloc_ready, src1, src2, rs1_busy, rs2_busy, err
  );

endinterface

// File: rtl/ysyx_22050612_sb_cnt.sv
// One pending-write counter of the scoreboard: counts allocations up and
// retires down, saturates at all ones and holds at zero, pulsing underflow
// when a retire arrives with nothing pending. The extra 'single' status
// output exists only when YSYX_22050612_RF_BYPASS_EN is defined.
module ysyx_22050612_sb_cnt #(
  parameter int CNT_WIDTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output logic full,
  output logic zero,
  output logic underflow
`ifdef YSYX_22050612_RF_BYPASS_EN
  ,
  output logic single
`endif
);

  logic [CNT_WIDTH-1:0] value;
  logic [CNT_WIDTH-1:0] value_next;

  assign full = &value;
  assign zero = (value == '0);
`ifdef YSYX_22050612_RF_BYPASS_EN
  assign single = (value == CNT_WIDTH'(1));
`endif

  // Next count; an alloc and a retire in the same cycle cancel out.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    value_next = value;
    underflow  = 1'b0;
    case ({inc, dec})
      2'b10: if (!full) value_next = value + CNT_WIDTH'(1);
      2'b01: begin
        if (zero) underflow = 1'b1;
        else      value_next = value - CNT_WIDTH'(1);
      end
      default: ;
    endcase
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
    if (rst) value <= '0;
    else     value <= value_next;
  end

endmodule

// File: rtl/ysyx_22050612_regfile_sb.sv
// Integer register file with a per-register pending-write scoreboard.
// Issue allocates destinations (marking them busy), writeback retires them,
// decode reads two sources with their busy status.
// Optional feature: define YSYX_22050612_RF_BYPASS_EN to forward the
// writeback data and the post-retire busy status to the read ports in the
// same cycle.
module ysyx_22050612_regfile_sb
  import ysyx_22050612_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int CNT_WIDTH  = 2
) (
  input logic                        clk,
  input logic                        rst,
  ysyx_22050612_regfile_sb_if.slave  bus
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(ZERO_REG);

  logic [DATA_WIDTH-1:0] rf [NUM_REGS];
  logic [NUM_REGS-1:0]   full_vec;
  logic [NUM_REGS-1:0]   zero_vec;
  logic [NUM_REGS-1:0]   uf_vec;
`ifdef YSYX_22050612_RF_BYPASS_EN
  logic [NUM_REGS-1:0]   single_vec;
`endif
  logic                  write_en;
  logic                  alloc_fire;

  assign write_en = bus.wen && (bus.waddr != ZERO_IDX);

  // Refuse only a full counter that is not being drained this very cycle.
  assign bus.alloc_ready = !((bus.alloc_rd != ZERO_IDX) && full_vec[bus.alloc_rd]
                             && !(bus.wen && (bus.waddr == bus.alloc_rd)));
  assign alloc_fire = bus.alloc_valid && bus.alloc_ready;

  // Register 0 has no counter: never full, never busy, never underflows.
  assign full_vec[0] = 1'b0;
  assign zero_vec[0] = 1'b1;
  assign uf_vec[0]   = 1'b0;
`ifdef YSYX_22050612_RF_BYPASS_EN
  assign single_vec[0] = 1'b0;
`endif

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_cnt
    ysyx_22050612_sb_cnt #(
      .CNT_WIDTH (CNT_WIDTH)
    ) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .inc       (alloc_fire && (bus.alloc_rd == ADDR_WIDTH'(i))),
      .dec       (bus.wen && (bus.waddr == ADDR_WIDTH'(i))),
      .full      (full_vec[i]),
      .zero      (zero_vec[i]),
      .underflow (uf_vec[i])
`ifdef YSYX_22050612_RF_BYPASS_EN
      ,
      .single    (single_vec[i])
`endif
    );
  end

  // Data storage; writes to register 0 are dropped.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the array is reset because reset must discard all architectural data, not just control state.
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
    end else if (write_en) begin
      rf[bus.waddr] <= bus.wdata;
    end
  end

  // Sticky flag for a retire that found no pending allocation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          bus.err <= 1'b0;
    else if (|uf_vec) bus.err <= 1'b1;
  end

  // Combinational read ports with register 0 hardwired to zero.
  always_comb begin
    bus.src1     = (bus.rs1 == ZERO_IDX) ? '0 : rf[bus.rs1];
    bus.src2     = (bus.rs2 == ZERO_IDX) ? '0 : rf[bus.rs2];
    bus.rs1_busy = !zero_vec[bus.rs1];
    bus.rs2_busy = !zero_vec[bus.rs2];
`ifdef YSYX_22050612_RF_BYPASS_EN
    if (write_en && (bus.rs1 == bus.waddr)) begin
      bus.src1     = bus.wdata;
      bus.rs1_busy = !zero_vec[bus.rs1] && !single_vec[bus.rs1];
    end
    if (write_en && (bus.rs2 == bus.waddr)) begin
      bus.src2     = bus.wdata;
      bus.rs2_busy = !zero_vec[bus.rs2] && !single_vec[bus.rs2];
    end
`endif
  end

endmodule
